d_bram_arbiter: RTL and testbench
=================================

Name: d_bram_arbiter

Overview:
- Two-requester arbiter and byte-lane controller for the single-port data BRAM: 32-bit word-addressed, 4-bit byte write enables, one-cycle registered read.
- Requester 0 is the CPU load/store unit; requester 1 is the debug/UART program loader.
- Converts byte-addressed LB/LH/LW/SB/SH/SW style requests into BRAM word accesses: lane enables, write-data replication, read extraction with sign/zero extension.
- Round-robin fairness; misaligned accesses are rejected without touching the BRAM.

Parameters:
- BRAM_ADDR_W, 10, BRAM word-address width (byte address is BRAM_ADDR_W+2 bits).
- DATA_W, 32, data width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- mX_req  in  1  request valid, X = 0,1 (CPU, loader)
- mX_we  in  1  1 = store, 0 = load
- mX_addr  in  BRAM_ADDR_W+2  byte address
- mX_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as misaligned)
- mX_uns  in  1  load zero-extend when 1, sign-extend when 0
- mX_wdata  in  32  store data, right-aligned
- mX_gnt  out  1  request accepted this cycle (combinational)
- mX_rvalid  out  1  load/error response valid, one-cycle pulse
- mX_rdata  out  32  extended load data
- mX_err  out  1  misaligned/reserved-size flag, qualified by mX_rvalid
- bram_we  out  4  to BRAM wea
- bram_addr  out  BRAM_ADDR_W  to BRAM addra (word address = mX_addr[BRAM_ADDR_W+1:2])
- bram_din  out  32  to BRAM dina
- bram_dout  in  32  from BRAM douta

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - last_grant <= 1, so m0 wins the first contention.
  - Response registers cleared; mX_rvalid=0, mX_err=0, mX_rdata=0.
  - While rst_n=0: mX_gnt=0 and bram_we=0 regardless of requests.
- Arbitration (combinational, cycle T):
  - Only one requesting: that requester wins.
  - Both requesting: the one not equal to last_grant wins.
  - Winner gets mX_gnt=1 in T; last_grant <= winner at the end of T.
  - No requests: last_grant holds, bram_we=0, bram_addr holds the last registered winner address (no spurious writes).
  - Sustained contention alternates 0,1,0,1; maximum wait is one cycle.
- Alignment check:
  - Misaligned = half with addr[0]=1, word with addr[1:0]!=0, or size=11.
  - A misaligned request is granted, but bram_we=0 and no write occurs.
  - At T+1: rvalid=1, err=1, rdata=0, for both loads and stores.
- Store, aligned, granted in T:
  - bram_addr = word address.
  - Byte: bram_we = 0001 << addr[1:0]; bram_din = wdata[7:0] replicated x4.
  - Half: bram_we = 0011 << addr[1:0]; bram_din = wdata[15:0] replicated x2.
  - Word: bram_we = 1111; bram_din = wdata.
  - The write commits at the T→T+1 edge. No rvalid is generated for a good store; gnt is the completion.
- Load, aligned, granted in T:
  - bram_we=0; owner, addr[1:0], size and uns are registered at the end of T.
  - At T+1: bram_dout is valid; the owner's rvalid=1, err=0.
  - rdata = selected lane(s) shifted to bit 0, then sign- or zero-extended per uns.
  - Latency is exactly 1 cycle after gnt. Back-to-back loads from either requester give one response per cycle.
- Read-after-write:
  - A load granted in the cycle after a store to the same word returns the new data.
  - The BRAM returns old data only on same-cycle read/write, which this block never issues.
- Response routing:
  - Only the registered owner's rvalid asserts; the other rvalid=0 and its rdata=0.
- Requesters hold req and payload stable until gnt. The arbiter does not buffer: an ungranted request is simply re-evaluated next cycle.
- Reset asserted while a load response is pending: the response is dropped and rvalid stays 0.

Decomposition:
- Shared package/header (extend SYSTEM_DEF.vh):
  - BRAM_ADDR_W
  - size codes SZ_B=00, SZ_H=01, SZ_W=10
  - requester IDs REQ_CPU=0, REQ_LDR=1
- Sub-module d_bram_lane_align (combinational):
  - Store side: size + offset + wdata → we mask + din.
  - Load side: dout + offset + size + uns → rdata.
  - Misaligned flag.
  - Instantiated once on the store path; the load-extract function is reused on the response path.

Test Plan:
- Reset, then m0 SW addr=0x004 wdata=0xDEADBEEF → m0_gnt in T, bram_we=1111, bram_addr=1; next-cycle m0 LW 0x004 → rvalid at T+1, rdata=0xDEADBEEF, err=0.
- m1 SB addr=0x006 wdata=0x000000A5 → bram_we=0100, bram_din=0xA5A5A5A5; then LB 0x006 uns=0 → rdata=0xFFFFFFA5; LBU → 0x000000A5.
- Both req every cycle from reset for 6 cycles → grants 0,1,0,1,0,1; each load response rvalid on the correct port only, one cycle after its gnt.
- m0 LH addr=0x003 and m0 SW addr=0x002 → gnt=1, bram_we=0000, next cycle rvalid=1, err=1, rdata=0; BRAM contents unchanged (verify by LW).
- SH addr=0x00A wdata=0x1234 over word 0xDEADBEEF at 0x008 → LW 0x008 returns 0x1234BEEF; LH 0x00A uns=0 → 0x00001234.
- Load granted, rst_n=0 asserted in the next cycle → no rvalid; after release, both request → m0 wins first.

Source files
------------

// File: rtl/d_bram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// d_bram_arbiter_pkg : shared constants and load-extract helper for data BRAM
// Revision 1.0
// ============================================================================
package d_bram_arbiter_pkg;

  localparam int BRAM_ADDR_W = 10;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  // Move the addressed lane(s) down to bit 0, then sign- or zero-extend.
  function automatic logic [31:0] load_extract(
    input logic [31:0] dout,
    input logic [1:0]  off,
    input logic [1:0]  size,
    input logic        uns
  );
    logic [31:0] sh;
    sh = dout >> {off, 3'b000};
    case (size)
      SZ_B:    load_extract = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_H:    load_extract = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      SZ_W:    load_extract = dout;
      default: load_extract = 32'h0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/d_bram_lane_align.sv
`default_nettype none
// ============================================================================
// d_bram_lane_align : byte-lane enables/replication for stores, lane extract for loads
// Revision 1.0
// ============================================================================
module d_bram_lane_align
  import d_bram_arbiter_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_we,
  output logic [31:0] st_din,
  output logic        misaligned,
  input  logic [31:0] ld_dout,
  input  logic [1:0]  ld_off,
  input  logic [1:0]  ld_size,
  input  logic        ld_uns,
  output logic [31:0] ld_rdata
);

  always_comb begin
    st_we  = 4'b0000;
    st_din = st_wdata;
    case (st_size)
      SZ_B: begin
        st_we  = 4'b0001 << st_off;
        st_din = {4{st_wdata[7:0]}};
      end
      SZ_H: begin
        st_we  = 4'b0011 << st_off;
        st_din = {2{st_wdata[15:0]}};
      end
      SZ_W: st_we = 4'b1111;
      default: st_we = 4'b0000;
    endcase
  end

  // Reserved size code is folded into the misaligned flag.
  always_comb begin
    misaligned = 1'b0;
    case (st_size)
      SZ_H:    misaligned = st_off[0];
      SZ_W:    misaligned = (st_off != 2'b00);
      SZ_B:    misaligned = 1'b0;
      default: misaligned = 1'b1;
    endcase
  end

  always_comb begin
    ld_rdata = load_extract(ld_dout, ld_off, ld_size, ld_uns);
  end

endmodule
`default_nettype wire

// File: rtl/d_bram_arbiter.sv
`default_nettype none
// ============================================================================
// d_bram_arbiter : round-robin CPU/loader arbiter and byte-lane controller for data BRAM
// Revision 1.0
// ============================================================================
module d_bram_arbiter #(
  parameter int BRAM_ADDR_W = d_bram_arbiter_pkg::BRAM_ADDR_W,
  parameter int DATA_W      = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   m0_req,
  input  logic                   m0_we,
  input  logic [BRAM_ADDR_W+1:0] m0_addr,
  input  logic [1:0]             m0_size,
  input  logic                   m0_uns,
  input  logic [DATA_W-1:0]      m0_wdata,
  output logic                   m0_gnt,
  output logic                   m0_rvalid,
  output logic [DATA_W-1:0]      m0_rdata,
  output logic                   m0_err,
  input  logic                   m1_req,
  input  logic                   m1_we,
  input  logic [BRAM_ADDR_W+1:0] m1_addr,
  input  logic [1:0]             m1_size,
  input  logic                   m1_uns,
  input  logic [DATA_W-1:0]      m1_wdata,
  output logic                   m1_gnt,
  output logic                   m1_rvalid,
  output logic [DATA_W-1:0]      m1_rdata,
  output logic                   m1_err,
  output logic [3:0]             bram_we,
  output logic [BRAM_ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0]      bram_din,
  input  logic [DATA_W-1:0]      bram_dout
);
  import d_bram_arbiter_pkg::*;

  logic                   r_last_grant;
  logic                   r_owner;
  logic                   r_rsp_valid;
  logic                   r_rsp_err;
  logic [1:0]             r_ld_off;
  logic [1:0]             r_ld_size;
  logic                   r_ld_uns;
  logic [BRAM_ADDR_W-1:0] r_addr;

  logic                   w_sel0, w_sel1, w_any, w_win;
  logic                   w_we, w_uns, w_mis;
  logic [BRAM_ADDR_W+1:0] w_addr;
  logic [1:0]             w_size;
  logic [DATA_W-1:0]      w_wdata, w_din, w_ld_rdata;
  logic [3:0]             w_mask;
  logic                   w_rv0, w_rv1;

  // On contention the requester that did not win last time goes first.
  always_comb begin
    w_sel0 = rst_n && m0_req && (!m1_req || (r_last_grant == REQ_LDR));
    w_sel1 = rst_n && m1_req && !w_sel0;
  end

  assign w_any   = w_sel0 | w_sel1;
  assign w_win   = w_sel1 ? REQ_LDR : REQ_CPU;
  assign w_we    = w_sel1 ? m1_we    : m0_we;
  assign w_addr  = w_sel1 ? m1_addr  : m0_addr;
  assign w_size  = w_sel1 ? m1_size  : m0_size;
  assign w_uns   = w_sel1 ? m1_uns   : m0_uns;
  assign w_wdata = w_sel1 ? m1_wdata : m0_wdata;

  assign m0_gnt = w_sel0;
  assign m1_gnt = w_sel1;

  d_bram_lane_align u_lane_align (
    .st_size    (w_size),
    .st_off     (w_addr[1:0]),
    .st_wdata   (w_wdata),
    .st_we      (w_mask),
    .st_din     (w_din),
    .misaligned (w_mis),
    .ld_dout    (bram_dout),
    .ld_off     (r_ld_off),
    .ld_size    (r_ld_size),
    .ld_uns     (r_ld_uns),
    .ld_rdata   (w_ld_rdata)
  );

  assign bram_we   = (w_any && w_we && !w_mis) ? w_mask : 4'b0000;
  assign bram_addr = w_any ? w_addr[BRAM_ADDR_W+1:2] : r_addr;
  assign bram_din  = w_din;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_grant <= REQ_LDR;
      r_owner      <= REQ_CPU;
      r_rsp_valid  <= 1'b0;
      r_rsp_err    <= 1'b0;
      r_ld_off     <= 2'b00;
      r_ld_size    <= SZ_W;
      r_ld_uns     <= 1'b0;
      r_addr       <= '0;
    end else if (w_any) begin
      r_last_grant <= w_win;
      r_owner      <= w_win;
      // Good stores complete at grant; loads and any misaligned access respond next cycle.
      r_rsp_valid  <= !w_we || w_mis;
      r_rsp_err    <= w_mis;
      r_ld_off     <= w_addr[1:0];
      r_ld_size    <= w_size;
      r_ld_uns     <= w_uns;
      r_addr       <= w_addr[BRAM_ADDR_W+1:2];
    end else begin
      r_rsp_valid  <= 1'b0;
      r_rsp_err    <= 1'b0;
    end
  end

  // Gating with rst_n drops a response whose cycle coincides with reset.
  assign w_rv0 = rst_n && r_rsp_valid && (r_owner == REQ_CPU);
  assign w_rv1 = rst_n && r_rsp_valid && (r_owner == REQ_LDR);

  assign m0_rvalid = w_rv0;
  assign m1_rvalid = w_rv1;
  assign m0_err    = w_rv0 && r_rsp_err;
  assign m1_err    = w_rv1 && r_rsp_err;
  assign m0_rdata  = (w_rv0 && !r_rsp_err) ? w_ld_rdata : '0;
  assign m1_rdata  = (w_rv1 && !r_rsp_err) ? w_ld_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_d_bram_arbiter.sv
`default_nettype none
// ============================================================================
// tb_d_bram_arbiter : directed stimulus, byte-level reference model and literal checks
// Revision 1.0
// ============================================================================
module tb_d_bram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        m0_req, m0_we, m0_uns, m1_req, m1_we, m1_uns;
  logic [11:0] m0_addr, m1_addr;
  logic [1:0]  m0_size, m1_size;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [3:0]  bram_we;
  logic [9:0]  bram_addr;
  logic [31:0] bram_din;
  logic [31:0] bram_dout;

  int n_checks = 0;
  int n_fail   = 0;

  d_bram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_size(m0_size),
    .m0_uns(m0_uns), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid),
    .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_size(m1_size),
    .m1_uns(m1_uns), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
    .m1_rdata(m1_rdata), .m1_err(m1_err),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(bram_dout)
  );

  // Single-port BRAM with registered read
  logic [31:0] bram [0:1023];
  logic [31:0] bram_nw;
  initial begin
    for (int i = 0; i < 1024; i++) bram[i] = 32'h0;
    bram_dout = 32'h0;
  end
  always @(posedge clk) begin
    bram_nw = bram[bram_addr];
    for (int i = 0; i < 4; i++)
      if (bram_we[i]) bram_nw[8*i +: 8] = bram_din[8*i +: 8];
    bram[bram_addr] <= bram_nw;
    bram_dout       <= bram[bram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte-addressed memory, round-robin pointer, one pending response
  logic [7:0]  ref_mem [0:4095];
  logic        m_last, m_pv, m_po, m_perr;
  logic [31:0] m_prd;
  logic        e_g0, e_g1, m_p, m_we, m_uns, m_mis;
  logic [11:0] m_a;
  logic [1:0]  m_sz;
  logic [31:0] m_wd, m_val, m_ones;
  logic [3:0]  e_we;
  int          nb, ia, lane;

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h0;
    m_last = 1'b1;
    m_pv   = 1'b0;
    m_po   = 1'b0;
    m_perr = 1'b0;
    m_prd  = 32'h0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chkb("mdl_rst_gnt0", m0_gnt, 1'b0);
      chkb("mdl_rst_gnt1", m1_gnt, 1'b0);
      chk ("mdl_rst_we", 32'(bram_we), 32'h0);
      chkb("mdl_rst_rv0", m0_rvalid, 1'b0);
      chkb("mdl_rst_rv1", m1_rvalid, 1'b0);
      m_last = 1'b1;
      m_pv   = 1'b0;
    end else begin
      chkb("mdl_rv0", m0_rvalid, m_pv && !m_po);
      chkb("mdl_rv1", m1_rvalid, m_pv && m_po);
      chkb("mdl_err0", m0_err, m_pv && !m_po && m_perr);
      chkb("mdl_err1", m1_err, m_pv && m_po && m_perr);
      chk ("mdl_rd0", m0_rdata, (m_pv && !m_po) ? m_prd : 32'h0);
      chk ("mdl_rd1", m1_rdata, (m_pv && m_po) ? m_prd : 32'h0);

      e_g0  = m0_req && (!m1_req || m_last);
      e_g1  = m1_req && !e_g0;
      m_p   = e_g1;
      m_we  = m_p ? m1_we : m0_we;
      m_a   = m_p ? m1_addr : m0_addr;
      m_sz  = m_p ? m1_size : m0_size;
      m_uns = m_p ? m1_uns : m0_uns;
      m_wd  = m_p ? m1_wdata : m0_wdata;
      ia    = int'(m_a);
      nb    = (m_sz == 2'b00) ? 1 : (m_sz == 2'b01) ? 2 : 4;
      m_mis = (m_sz == 2'b11) || ((ia % nb) != 0);
      e_we  = 4'b0000;
      m_val = 32'h0;

      chkb("mdl_gnt0", m0_gnt, e_g0);
      chkb("mdl_gnt1", m1_gnt, e_g1);

      if (e_g0 || e_g1) begin
        chk("mdl_addr", 32'(bram_addr), 32'(m_a[11:2]));
        if (m_we && !m_mis) begin
          for (int b = 0; b < nb; b++) begin
            lane = (ia % 4) + b;
            e_we[lane] = 1'b1;
            ref_mem[ia + b] = m_wd[8*b +: 8];
            chk("mdl_din_lane", 32'(bram_din[8*lane +: 8]), 32'(m_wd[8*b +: 8]));
          end
        end else if (!m_we && !m_mis) begin
          for (int b = 0; b < nb; b++) m_val = m_val | (32'(ref_mem[ia + b]) << (8*b));
          m_ones = 32'hFFFF_FFFF;
          if (!m_uns && nb < 4 && ref_mem[ia + nb - 1][7]) m_val = m_val | (m_ones << (8*nb));
        end
        m_last = m_p;
      end
      chk("mdl_we", 32'(bram_we), 32'(e_we));

      m_pv   = (e_g0 || e_g1) && (!m_we || m_mis);
      m_po   = m_p;
      m_perr = m_mis;
      m_prd  = m_mis ? 32'h0 : m_val;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic idle();
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  task automatic drive(input bit p, input bit we, input logic [11:0] a,
                       input logic [1:0] sz, input bit u, input logic [31:0] wd);
    if (!p) begin
      m0_req = 1'b1; m0_we = we; m0_addr = a; m0_size = sz; m0_uns = u; m0_wdata = wd;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_addr = a; m1_size = sz; m1_uns = u; m1_wdata = wd;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_size = 0; m0_uns = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_size = 0; m1_uns = 0; m1_wdata = 0;
    drive(0, 1, 12'h004, 2'b10, 0, 32'h1111_1111);
    tick(); tick(); look();
    chkb("rst_gnt0", m0_gnt, 1'b0);
    chk ("rst_we", 32'(bram_we), 32'h0);
    chkb("rst_rv0", m0_rvalid, 1'b0);
    chk ("rst_rd0", m0_rdata, 32'h0);

    // SW then LW on the CPU port
    tick(); rst_n = 1'b1; drive(0, 1, 12'h004, 2'b10, 0, 32'hDEAD_BEEF);
    look();
    chkb("sw_gnt0", m0_gnt, 1'b1);
    chk ("sw_we", 32'(bram_we), 32'hF);
    chk ("sw_addr", 32'(bram_addr), 32'h1);
    chk ("sw_din", bram_din, 32'hDEAD_BEEF);
    tick(); drive(0, 0, 12'h004, 2'b10, 0, 32'h0);
    look();
    chkb("lw_gnt0", m0_gnt, 1'b1);
    chk ("lw_we", 32'(bram_we), 32'h0);
    tick(); idle();
    look();
    chkb("lw_rv0", m0_rvalid, 1'b1);
    chk ("lw_rd0", m0_rdata, 32'hDEAD_BEEF);
    chkb("lw_err0", m0_err, 1'b0);
    chkb("lw_rv1", m1_rvalid, 1'b0);

    // Loader byte store and signed/unsigned byte loads
    tick(); drive(1, 1, 12'h006, 2'b00, 0, 32'h0000_00A5);
    look();
    chkb("sb_gnt1", m1_gnt, 1'b1);
    chk ("sb_we", 32'(bram_we), 32'h4);
    chk ("sb_din", bram_din, 32'hA5A5_A5A5);
    tick(); drive(1, 0, 12'h006, 2'b00, 0, 32'h0);
    look();
    tick(); drive(1, 0, 12'h006, 2'b00, 1, 32'h0);
    look();
    chkb("lb_rv1", m1_rvalid, 1'b1);
    chk ("lb_rd1", m1_rdata, 32'hFFFF_FFA5);
    tick(); idle();
    look();
    chk ("lbu_rd1", m1_rdata, 32'h0000_00A5);

    // Sustained contention from reset
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    drive(0, 0, 12'h004, 2'b10, 0, 32'h0);
    drive(1, 0, 12'h006, 2'b01, 1, 32'h0);
    for (int i = 0; i < 6; i++) begin
      look();
      chkb("rr_gnt0", m0_gnt, (i % 2) == 0);
      chkb("rr_gnt1", m1_gnt, (i % 2) == 1);
      if (i > 0) begin
        chkb("rr_rv0", m0_rvalid, ((i - 1) % 2) == 0);
        chkb("rr_rv1", m1_rvalid, ((i - 1) % 2) == 1);
      end
      tick();
      if (i == 5) idle();
    end
    look();
    chkb("rr_last_rv1", m1_rvalid, 1'b1);
    chk ("rr_last_rd1", m1_rdata, 32'h0000_DEA5);

    // Misaligned accesses
    tick(); drive(0, 0, 12'h003, 2'b01, 0, 32'h0);
    look();
    chkb("ma_lh_gnt", m0_gnt, 1'b1);
    chk ("ma_lh_we", 32'(bram_we), 32'h0);
    tick(); drive(0, 1, 12'h002, 2'b10, 0, 32'hFFFF_FFFF);
    look();
    chkb("ma_lh_rv", m0_rvalid, 1'b1);
    chkb("ma_lh_err", m0_err, 1'b1);
    chk ("ma_lh_rd", m0_rdata, 32'h0);
    chkb("ma_sw_gnt", m0_gnt, 1'b1);
    chk ("ma_sw_we", 32'(bram_we), 32'h0);
    tick(); drive(0, 0, 12'h000, 2'b10, 0, 32'h0);
    look();
    chkb("ma_sw_rv", m0_rvalid, 1'b1);
    chkb("ma_sw_err", m0_err, 1'b1);
    tick(); idle();
    look();
    chkb("ma_chk_rv", m0_rvalid, 1'b1);
    chkb("ma_chk_err", m0_err, 1'b0);
    chk ("ma_chk_rd", m0_rdata, 32'h0);

    // Halfword store into a word
    tick(); drive(0, 1, 12'h008, 2'b10, 0, 32'hDEAD_BEEF);
    look();
    tick(); drive(0, 1, 12'h00A, 2'b01, 0, 32'h0000_1234);
    look();
    chk ("sh_we", 32'(bram_we), 32'hC);
    chk ("sh_din", bram_din, 32'h1234_1234);
    tick(); drive(0, 0, 12'h008, 2'b10, 0, 32'h0);
    look();
    tick(); drive(0, 0, 12'h00A, 2'b01, 0, 32'h0);
    look();
    chk ("sh_lw_rd", m0_rdata, 32'h1234_BEEF);
    tick(); idle();
    look();
    chk ("sh_lh_rd", m0_rdata, 32'h0000_1234);

    // Reset while a load response is pending
    tick(); drive(1, 0, 12'h008, 2'b10, 0, 32'h0);
    look();
    chkb("rp_gnt1", m1_gnt, 1'b1);
    tick(); idle(); rst_n = 1'b0;
    look();
    chkb("rp_rv1", m1_rvalid, 1'b0);
    tick(); rst_n = 1'b1;
    drive(0, 0, 12'h00A, 2'b01, 1, 32'h0);
    drive(1, 0, 12'h008, 2'b10, 0, 32'h0);
    look();
    chkb("rp_gnt0", m0_gnt, 1'b1);
    chkb("rp_gnt1", m1_gnt, 1'b0);
    tick(); idle();
    look();
    chkb("rp_rv0", m0_rvalid, 1'b1);
    chk ("rp_rd0", m0_rdata, 32'h0000_1234);

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
